falafel_lsu: RTL and testbench
==============================

# falafel_lsu

Load/store unit between the allocator core and the shared heap memory. Accepts one header request at a time from the core (LOCK, UNLOCK, LOAD, EDIT_NEXT_ADDR, EDIT_SIZE_AND_NEXT_ADDR), breaks it into word-wide memory transactions, and returns a single-cycle response. LOCK is a spin lock built on an atomic swap with backoff.

## Interface
- DATA_W, 64: word and address width in bits; taken from falafel_pkg.
- LOCK_ADDR, 'h0: byte address of the heap lock word.
- BACKOFF_CYCLES, 4: idle cycles between failed LOCK swap attempts; must be ≥1.
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- req_i  in  header_req_t  core request: {val, lsu_op, header{addr,size,next_addr}}.
- lsu_ready_o  out  1  high when a request can be accepted.
- rsp_o  out  header_rsp_t  {val, header}; val is a one-cycle pulse.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_req_op_o  out  mem_op_e  MEM_READ, MEM_WRITE or MEM_SWAP.
- mem_req_addr_o  out  DATA_W  byte address.
- mem_req_wdata_o  out  DATA_W  write or swap data.
- mem_rsp_valid_i  in  1  response for reads, writes and swaps.
- mem_rsp_rdata_i  in  DATA_W  read data, or the old value for a swap.

## Operation
- Header layout: size at addr, next_addr at addr+NEXT_ADDR_OFFSET (DATA_W/8). Sums are modulo 2^DATA_W.
- Accept: the request is taken when req_i.val && lsu_ready_o. The op and header are latched, and lsu_ready_o drops the next cycle.
- Beat sequences per op:
  - LOAD: READ addr → size, then READ addr+8 → next_addr. Response header = {latched addr, size, next_addr}.
  - EDIT_NEXT_ADDR: WRITE addr+8 ← next_addr.
  - EDIT_SIZE_AND_NEXT_ADDR: WRITE addr ← size, then WRITE addr+8 ← next_addr.
  - LOCK: SWAP LOCK_ADDR ← 1. If the old value is 0 → done. Otherwise → BACKOFF for BACKOFF_CYCLES, then retry. There is no retry limit.
  - UNLOCK: WRITE LOCK_ADDR ← 0.
  - Undefined op: no memory access; go to RESPOND the next cycle.
- For every op except LOAD, the response header is the latched request header.
- States:
  - IDLE: lsu_ready_o=1.
  - MEM_REQ: mem_req_valid_o=1; leave on mem_req_ready_i.
  - MEM_WAIT: wait for mem_rsp_valid_i.
  - BACKOFF: count down.
  - RESPOND: rsp_o.val=1.
- Transitions:
  - IDLE→MEM_REQ on accept.
  - MEM_REQ→MEM_WAIT on mem_req_ready_i.
  - MEM_WAIT→MEM_REQ if beats remain.
  - MEM_WAIT→BACKOFF on a failed LOCK.
  - MEM_WAIT→RESPOND when the op is complete.
  - BACKOFF→MEM_REQ when the counter reaches 0.
  - RESPOND→IDLE unconditionally.
- A 1-bit beat index selects the first or second word. It is cleared on accept.
- mem_req_* are held stable while mem_req_valid_o && !mem_req_ready_i.
- At most one memory transaction is outstanding. mem_rsp_valid_i is ignored outside MEM_WAIT.
- req_i.val while busy is ignored; it is not queued.

## Timing
- Reset values:
  - lsu_ready_o=1, rsp_o='0.
  - mem_req_valid_o=0, mem_req_op_o=MEM_READ, mem_req_addr_o='0, mem_req_wdata_o='0.
  - state IDLE, backoff counter 0.
- All outputs are registered or decoded from registered state only; nothing combinational from req_i.
- Zero-wait memory (ready=1, response the cycle after acceptance) costs 2 cycles per beat. Accept at cycle 0 gives:
  - rsp_o.val at cycle 3 for single-beat ops (EDIT_NEXT_ADDR, UNLOCK, uncontended LOCK).
  - rsp_o.val at cycle 5 for LOAD and EDIT_SIZE_AND_NEXT_ADDR.
  - rsp_o.val at cycle 1 for an undefined op.
- lsu_ready_o returns to 1 the cycle after rsp_o.val.
- Each failed LOCK attempt adds 2 + BACKOFF_CYCLES cycles.
- Reset mid-operation: return to IDLE immediately. Drop mem_req_valid_o and discard any later memory response. A lock swap that was in flight is not undone; software re-initialises the lock word.

## Structure
- falafel_pkg holds header_t, header_req_t, header_rsp_t, req_lsu_op_e, the new mem_op_e, NEXT_ADDR_OFFSET and LOCK_ADDR_DEFAULT.
- Local FSM enum lsu_state_e stays inside falafel_lsu.
- No sub-module; the backoff counter and beat index are in-module.

## Test plan
- LOAD addr='h10, memory ['h10]=32, ['h18]='h80, zero-wait → reads of 'h10 then 'h18; rsp_o.val at cycle 5 with header {'h10, 32, 'h80}.
- EDIT_SIZE_AND_NEXT_ADDR {addr 'h40, size 16, next 'h100}, mem_req_ready_i low for 3 cycles on beat 0 → request held stable; writes 'h40←16 then 'h48←'h100; one rsp pulse.
- LOCK with lock word=1 for 2 swaps then 0, BACKOFF_CYCLES=4 → 3 swaps to 'h0 separated by 4 idle cycles; rsp only after the third swap.
- UNLOCK → single WRITE 'h0←0; rsp at cycle 3; lsu_ready_o high at cycle 4.
- req_i.val held high during a LOAD, then rst_ni asserted during the MEM_WAIT of beat 1 → no extra request accepted while busy; after reset all outputs are at reset values and a late mem_rsp_valid_i produces no rsp_o.val.
- Undefined lsu_op → no mem_req_valid_o; rsp_o.val at cycle 1 echoing the request header.

Source files
------------

// File: rtl/falafel_pkg.sv
// falafel_pkg: shared types for the falafel heap load/store unit.
// Header layout, core request/response bundles and memory opcodes.
package falafel_pkg;

    localparam int DATA_W = 64;
    localparam logic [DATA_W-1:0] NEXT_ADDR_OFFSET =
        DATA_W'(DATA_W / 8);
    localparam logic [DATA_W-1:0] LOCK_ADDR_DEFAULT = '0;

    typedef enum logic [2:0] {
        LSU_LOCK                    = 3'd0,
        LSU_UNLOCK                  = 3'd1,
        LSU_LOAD                    = 3'd2,
        LSU_EDIT_NEXT_ADDR          = 3'd3,
        LSU_EDIT_SIZE_AND_NEXT_ADDR = 3'd4
    } req_lsu_op_e;

    typedef enum logic [1:0] {
        MEM_READ  = 2'd0,
        MEM_WRITE = 2'd1,
        MEM_SWAP  = 2'd2
    } mem_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] size;
        logic [DATA_W-1:0] next_addr;
    } header_t;

    typedef struct packed {
        logic        val;
        req_lsu_op_e lsu_op;
        header_t     header;
    } header_req_t;

    typedef struct packed {
        logic    val;
        header_t header;
    } header_rsp_t;

    typedef struct packed {
        mem_op_e           op;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    function automatic logic op_is_defined(input req_lsu_op_e op);
        return op inside {LSU_LOCK, LSU_UNLOCK, LSU_LOAD,
                          LSU_EDIT_NEXT_ADDR,
                          LSU_EDIT_SIZE_AND_NEXT_ADDR};
    endfunction

endpackage

// File: rtl/falafel_lsu.sv
// falafel_lsu: turns one header request into word memory beats.
// LOCK spins on an atomic swap with a fixed backoff between tries.
module falafel_lsu
    import falafel_pkg::*;
#(
    parameter logic [DATA_W-1:0] LOCK_ADDR      = LOCK_ADDR_DEFAULT,
    parameter int                BACKOFF_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  header_req_t       req_i,
    output logic              lsu_ready_o,
    output header_rsp_t       rsp_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output mem_op_e           mem_req_op_o,
    output logic [DATA_W-1:0] mem_req_addr_o,
    output logic [DATA_W-1:0] mem_req_wdata_o,
    input  logic              mem_rsp_valid_i,
    input  logic [DATA_W-1:0] mem_rsp_rdata_i
);

    localparam int CNT_W =
        (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BACKOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_BACKOFF,
        S_RESPOND
    } lsu_state_e;

    lsu_state_e  r_state;
    req_lsu_op_e r_op;
    header_t     r_hdr;
    logic        r_beat;
    logic [CNT_W-1:0] r_cnt;
    logic        r_ready;
    header_rsp_t r_rsp;
    logic        r_mem_valid;
    mem_cmd_t    r_mem_cmd;

    logic        w_last_beat;
    logic        w_lock_fail;
    header_t     w_done_hdr;

    // Memory command for a given op and beat (0 = first word).
    function automatic mem_cmd_t beat_cmd(
        input req_lsu_op_e op,
        input logic        beat,
        input header_t     h
    );
        mem_cmd_t c;
        c = '0;
        case (op)
            LSU_LOAD: begin
                c.op   = MEM_READ;
                c.addr = beat ? h.addr + NEXT_ADDR_OFFSET : h.addr;
            end
            LSU_EDIT_NEXT_ADDR: begin
                c.op    = MEM_WRITE;
                c.addr  = h.addr + NEXT_ADDR_OFFSET;
                c.wdata = h.next_addr;
            end
            LSU_EDIT_SIZE_AND_NEXT_ADDR: begin
                c.op    = MEM_WRITE;
                c.addr  = beat ? h.addr + NEXT_ADDR_OFFSET : h.addr;
                c.wdata = beat ? h.next_addr : h.size;
            end
            LSU_LOCK: begin
                c.op    = MEM_SWAP;
                c.addr  = LOCK_ADDR;
                c.wdata = DATA_W'(1);
            end
            LSU_UNLOCK: begin
                c.op    = MEM_WRITE;
                c.addr  = LOCK_ADDR;
                c.wdata = '0;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign w_last_beat = r_beat ||
        !(r_op inside {LSU_LOAD, LSU_EDIT_SIZE_AND_NEXT_ADDR});
    assign w_lock_fail = (r_op == LSU_LOCK) && (mem_rsp_rdata_i != '0);

    // Response header: LOAD takes next_addr from the final read.
    always_comb begin
        w_done_hdr = r_hdr;
        if (r_op == LSU_LOAD) begin
            w_done_hdr.next_addr = mem_rsp_rdata_i;
        end
    end

    // Main FSM with registered handshake and memory outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_op        <= LSU_LOCK;
            r_hdr       <= '0;
            r_beat      <= 1'b0;
            r_cnt       <= '0;
            r_ready     <= 1'b1;
            r_rsp       <= '0;
            r_mem_valid <= 1'b0;
            r_mem_cmd   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_i.val) begin
                        r_op    <= req_i.lsu_op;
                        r_hdr   <= req_i.header;
                        r_beat  <= 1'b0;
                        r_ready <= 1'b0;
                        if (op_is_defined(req_i.lsu_op)) begin
                            r_state     <= S_MEM_REQ;
                            r_mem_valid <= 1'b1;
                            r_mem_cmd   <= beat_cmd(req_i.lsu_op, 1'b0,
                                                    req_i.header);
                        end else begin
                            r_state      <= S_RESPOND;
                            r_rsp.val    <= 1'b1;
                            r_rsp.header <= req_i.header;
                        end
                    end
                end
                S_MEM_REQ: begin
                    if (mem_req_ready_i) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        if (w_lock_fail) begin
                            r_state <= S_BACKOFF;
                            r_cnt   <= CNT_LOAD;
                        end else if (!w_last_beat) begin
                            r_beat      <= 1'b1;
                            r_state     <= S_MEM_REQ;
                            r_mem_valid <= 1'b1;
                            r_mem_cmd   <= beat_cmd(r_op, 1'b1, r_hdr);
                            if (r_op == LSU_LOAD) begin
                                r_hdr.size <= mem_rsp_rdata_i;
                            end
                        end else begin
                            r_state      <= S_RESPOND;
                            r_rsp.val    <= 1'b1;
                            r_rsp.header <= w_done_hdr;
                        end
                    end
                end
                S_BACKOFF: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_MEM_REQ;
                        r_mem_valid <= 1'b1;
                        r_mem_cmd   <= beat_cmd(r_op, r_beat, r_hdr);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESPOND: begin
                    r_rsp.val <= 1'b0;
                    r_ready   <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign lsu_ready_o     = r_ready;
    assign rsp_o           = r_rsp;
    assign mem_req_valid_o = r_mem_valid;
    assign mem_req_op_o    = r_mem_cmd.op;
    assign mem_req_addr_o  = r_mem_cmd.addr;
    assign mem_req_wdata_o = r_mem_cmd.wdata;

endmodule

// File: tb/tb_falafel_lsu.sv
// tb_falafel_lsu: vector table, corner sequences and random ops
// against a word-memory reference model of the heap header rules.
module tb_falafel_lsu;
    import falafel_pkg::*;

    localparam int BO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    header_req_t req = '0;
    header_rsp_t rsp;
    logic        lsu_ready;
    logic        mreq_valid;
    logic        mreq_ready = 1'b1;
    mem_op_e     mreq_op;
    logic [63:0] mreq_addr;
    logic [63:0] mreq_wdata;
    logic        mrsp_valid = 1'b0;
    logic [63:0] mrsp_rdata = '0;

    always #5 clk = ~clk;

    falafel_lsu #(
        .LOCK_ADDR      (64'h0),
        .BACKOFF_CYCLES (BO)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_i           (req),
        .lsu_ready_o     (lsu_ready),
        .rsp_o           (rsp),
        .mem_req_valid_o (mreq_valid),
        .mem_req_ready_i (mreq_ready),
        .mem_req_op_o    (mreq_op),
        .mem_req_addr_o  (mreq_addr),
        .mem_req_wdata_o (mreq_wdata),
        .mem_rsp_valid_i (mrsp_valid),
        .mem_rsp_rdata_i (mrsp_rdata)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        mem_op_e     op;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          c;
    } beat_t;

    beat_t       log_q[$];
    beat_t       exp_q[$];
    logic [63:0] mem[logic [63:0]];
    logic [63:0] mm[logic [63:0]];

    int          stall_cnt = 0;
    int          rsp_lat = 1;
    int          pend = 0;
    int          swap_fail = 0;
    logic [63:0] pend_data = '0;
    logic        prev_stall = 1'b0;
    logic [129:0] snap = '0;

    task automatic chk(input string nm, input logic [191:0] act,
                       input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    function automatic logic [63:0] mrd(input logic [63:0] a);
        return mm.exists(a) ? mm[a] : 64'h0;
    endfunction

    function automatic header_t mkh(input logic [63:0] a,
                                    input logic [63:0] s,
                                    input logic [63:0] n);
        header_t h;
        h.addr = a;
        h.size = s;
        h.next_addr = n;
        return h;
    endfunction

    // Heap memory: optional stalls, fixed response latency.
    always @(negedge clk) begin
        mrsp_valid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mrsp_valid = 1'b1;
                mrsp_rdata = pend_data;
            end
        end
        if (mreq_valid && prev_stall) begin
            chk("req_held_stable",
                {mreq_op, mreq_addr, mreq_wdata}, snap);
        end
        if (mreq_valid && stall_cnt > 0) begin
            mreq_ready = 1'b0;
            stall_cnt--;
            prev_stall = 1'b1;
            snap = {mreq_op, mreq_addr, mreq_wdata};
        end else begin
            mreq_ready = 1'b1;
            prev_stall = 1'b0;
            if (mreq_valid) begin
                log_q.push_back('{op: mreq_op, addr: mreq_addr,
                                  wdata: mreq_wdata, c: cyc});
                pend_data = '0;
                case (mreq_op)
                    MEM_READ: pend_data = rd(mreq_addr);
                    MEM_WRITE: mem[mreq_addr] = mreq_wdata;
                    MEM_SWAP: begin
                        if (swap_fail > 0) begin
                            pend_data = 64'h1;
                            swap_fail--;
                        end else begin
                            pend_data = rd(mreq_addr);
                            mem[mreq_addr] = mreq_wdata;
                        end
                    end
                    default: pend_data = '0;
                endcase
                pend = rsp_lat;
            end
        end
    end

    logic    t_got;
    int      t_lat;
    header_t t_hdr;

    task automatic send(input req_lsu_op_e op, input header_t h);
        @(negedge clk);
        chk("ready_before_req", lsu_ready, 1);
        req.val = 1'b1;
        req.lsu_op = op;
        req.header = h;
        log_q.delete();
        t_got = 1'b0;
        t_lat = 0;
        for (int k = 1; k <= 400 && !t_got; k++) begin
            @(negedge clk);
            req.val = 1'b0;
            if (rsp.val) begin
                t_got = 1'b1;
                t_lat = k;
                t_hdr = rsp.header;
            end
        end
        if (!t_got) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout: actual=none required=pulse");
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            @(negedge clk);
            chk("rsp_single_pulse", rsp.val, 0);
            chk("ready_after_rsp", lsu_ready, 1);
        end
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_beats"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < log_q.size()) begin
                chk({nm, "_op"}, log_q[i].op, exp_q[i].op);
                chk({nm, "_addr"}, log_q[i].addr, exp_q[i].addr);
                if (exp_q[i].op != MEM_READ) begin
                    chk({nm, "_wdata"}, log_q[i].wdata,
                        exp_q[i].wdata);
                end
            end
        end
    endtask

    typedef struct {
        req_lsu_op_e op;
        header_t     h;
        logic [63:0] pa0;
        logic [63:0] pv0;
        logic [63:0] pa1;
        logic [63:0] pv1;
        header_t     exp_h;
        int          exp_lat;
        int          exp_beats;
        logic [63:0] exp_a0;
    } vec_t;

    vec_t tv[9];

    initial begin
        logic        locked;
        int          r;
        int          fails;
        req_lsu_op_e op;
        header_t     h;
        header_t     eh;
        logic [63:0] a;
        int          seen;

        tv[0] = '{LSU_LOAD, mkh(64'h10, 0, 0),
                  64'h10, 64'd32, 64'h18, 64'h80,
                  mkh(64'h10, 64'd32, 64'h80), 5, 2, 64'h10};
        tv[1] = '{LSU_EDIT_NEXT_ADDR, mkh(64'h20, 5, 64'h300),
                  64'h800, 0, 64'h800, 0,
                  mkh(64'h20, 5, 64'h300), 3, 1, 64'h28};
        tv[2] = '{LSU_EDIT_SIZE_AND_NEXT_ADDR,
                  mkh(64'h40, 64'd16, 64'h100),
                  64'h800, 0, 64'h800, 0,
                  mkh(64'h40, 64'd16, 64'h100), 5, 2, 64'h40};
        tv[3] = '{LSU_LOAD, mkh(64'hFFFF_FFFF_FFFF_FFF8, 0, 0),
                  64'hFFFF_FFFF_FFFF_FFF8, 64'd7, 64'h0, 64'd9,
                  mkh(64'hFFFF_FFFF_FFFF_FFF8, 7, 9), 5, 2,
                  64'hFFFF_FFFF_FFFF_FFF8};
        tv[4] = '{LSU_UNLOCK, mkh(1, 2, 3),
                  64'h800, 0, 64'h800, 0,
                  mkh(1, 2, 3), 3, 1, 64'h0};
        tv[5] = '{LSU_LOCK, mkh(4, 5, 6),
                  64'h800, 0, 64'h800, 0,
                  mkh(4, 5, 6), 3, 1, 64'h0};
        tv[6] = '{req_lsu_op_e'(3'd6), mkh(64'h55, 64'h66, 64'h77),
                  64'h800, 0, 64'h800, 0,
                  mkh(64'h55, 64'h66, 64'h77), 1, 0, 64'h0};
        tv[7] = '{LSU_LOAD, mkh(64'h20, 64'h999, 64'h999),
                  64'h800, 0, 64'h800, 0,
                  mkh(64'h20, 0, 64'h300), 5, 2, 64'h20};
        tv[8] = '{LSU_LOAD, mkh(64'h40, 0, 0),
                  64'h800, 0, 64'h800, 0,
                  mkh(64'h40, 64'd16, 64'h100), 5, 2, 64'h40};

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", lsu_ready, 1);
        chk("rst_rsp_val", rsp.val, 0);
        chk("rst_rsp_hdr", rsp.header, 0);
        chk("rst_mreq_valid", mreq_valid, 0);
        chk("rst_mreq_op", mreq_op, MEM_READ);
        chk("rst_mreq_addr", mreq_addr, 0);
        chk("rst_mreq_wdata", mreq_wdata, 0);
        rst_n = 1'b1;

        // zero-wait vector table
        foreach (tv[i]) begin
            mem[tv[i].pa0] = tv[i].pv0;
            mem[tv[i].pa1] = tv[i].pv1;
            send(tv[i].op, tv[i].h);
            chk($sformatf("v%0d_lat", i), t_lat, tv[i].exp_lat);
            chk($sformatf("v%0d_hdr", i), t_hdr, tv[i].exp_h);
            chk($sformatf("v%0d_beats", i), log_q.size(),
                tv[i].exp_beats);
            if (tv[i].exp_beats > 0 && log_q.size() > 0) begin
                chk($sformatf("v%0d_addr0", i), log_q[0].addr,
                    tv[i].exp_a0);
            end
        end

        // beat 0 stalled for three cycles
        stall_cnt = 3;
        send(LSU_EDIT_SIZE_AND_NEXT_ADDR, mkh(64'h40, 16, 64'h100));
        chk("stall_lat", t_lat, 8);
        chk("stall_hdr", t_hdr, mkh(64'h40, 16, 64'h100));
        exp_q.delete();
        exp_q.push_back('{MEM_WRITE, 64'h40, 64'd16, 0});
        exp_q.push_back('{MEM_WRITE, 64'h48, 64'h100, 0});
        check_log("stall");

        // contended lock: two failed swaps then success
        mem[64'h0] = 64'h0;
        swap_fail = 2;
        send(LSU_LOCK, mkh(7, 8, 9));
        chk("lock_lat", t_lat, 3 + 2 * (2 + BO));
        chk("lock_hdr", t_hdr, mkh(7, 8, 9));
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{MEM_SWAP, 64'h0, 64'h1, 0});
        end
        check_log("lock");
        if (log_q.size() == 3) begin
            chk("lock_gap1", log_q[1].c - log_q[0].c, 2 + BO);
            chk("lock_gap2", log_q[2].c - log_q[1].c, 2 + BO);
        end

        // random ops against the reference model
        locked = 1'b1;
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            a = 64'h100 + 64'(8 * $urandom_range(0, 15));
            h = mkh(a, {$urandom, $urandom}, {$urandom, $urandom});
            fails = 0;
            exp_q.delete();
            eh = h;
            if (r < 3) begin
                op = LSU_LOAD;
                exp_q.push_back('{MEM_READ, a, 0, 0});
                exp_q.push_back('{MEM_READ, a + 8, 0, 0});
                eh = mkh(a, mrd(a), mrd(a + 8));
            end else if (r < 5) begin
                op = LSU_EDIT_NEXT_ADDR;
                exp_q.push_back('{MEM_WRITE, a + 8, h.next_addr, 0});
                mm[a + 8] = h.next_addr;
            end else if (r < 7) begin
                op = LSU_EDIT_SIZE_AND_NEXT_ADDR;
                exp_q.push_back('{MEM_WRITE, a, h.size, 0});
                exp_q.push_back('{MEM_WRITE, a + 8, h.next_addr, 0});
                mm[a] = h.size;
                mm[a + 8] = h.next_addr;
            end else if (r < 9 && locked) begin
                op = LSU_UNLOCK;
                exp_q.push_back('{MEM_WRITE, 64'h0, 64'h0, 0});
                locked = 1'b0;
            end else if (r < 9) begin
                op = LSU_LOCK;
                fails = $urandom_range(0, 2);
                for (int i = 0; i <= fails; i++) begin
                    exp_q.push_back('{MEM_SWAP, 64'h0, 64'h1, 0});
                end
                locked = 1'b1;
            end else begin
                op = req_lsu_op_e'(3'($urandom_range(5, 7)));
            end
            swap_fail = fails;
            stall_cnt = $urandom_range(0, 2);
            rsp_lat = $urandom_range(1, 3);
            send(op, h);
            if (t_got) begin
                chk($sformatf("rnd%0d_hdr", it), t_hdr, eh);
            end
            check_log($sformatf("rnd%0d", it));
        end
        stall_cnt = 0;
        swap_fail = 0;

        // reset in beat-1 wait with request held high
        rsp_lat = 4;
        @(negedge clk);
        req.val = 1'b1;
        req.lsu_op = LSU_LOAD;
        req.header = mkh(64'h10, 0, 0);
        log_q.delete();
        for (int k = 0; k < 50 && log_q.size() < 2; k++) begin
            @(negedge clk);
        end
        @(negedge clk);
        chk("busy_beats", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("busy_addr1", log_q[1].addr, 64'h18);
        end
        chk("busy_not_ready", lsu_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", lsu_ready, 1);
        chk("mid_rst_rsp_val", rsp.val, 0);
        chk("mid_rst_rsp_hdr", rsp.header, 0);
        chk("mid_rst_mreq_valid", mreq_valid, 0);
        chk("mid_rst_mreq_op", mreq_op, MEM_READ);
        chk("mid_rst_mreq_addr", mreq_addr, 0);
        chk("mid_rst_mreq_wdata", mreq_wdata, 0);
        req.val = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp.val || mreq_valid) seen++;
        end
        chk("late_rsp_ignored", seen, 0);
        chk("post_rst_ready", lsu_ready, 1);
        rsp_lat = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
